// File: rtl/mips_pkg.sv
// mips_pkg: shared WB control encodings, link offset and default datapath widths
package mips_pkg;
  localparam int DEF_DW = 32;
  localparam int DEF_AW = 5;
  localparam int LINK_OFFSET = 4;
  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_MEM  = 2'b10;
  localparam logic [1:0] WB_LINK = 2'b11;
endpackage

// File: rtl/wb_mux.sv
// wb_mux: wb_ctl select of write-back value (wr_data) and commit strobe (wr_en); r0 writes, bubbles and reset (rst low) suppress wr_en
module wb_mux
  import mips_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          rst,
  input  logic [1:0]    wb_ctl,
  input  logic [DW-1:0] wb_rd,
  input  logic [DW-1:0] wb_pc,
  input  logic [DW-1:0] wb_alu,
  input  logic [AW-1:0] wb_wn,
  output logic [DW-1:0] wr_data,
  output logic          wr_en
);
  always_comb begin
    wr_data = wb_ctl == WB_ALU  ? wb_alu :
              wb_ctl == WB_MEM  ? wb_rd :
              wb_ctl == WB_LINK ? wb_pc + DW'(LINK_OFFSET) : '0;
    wr_en   = rst && wb_ctl != WB_NONE && wb_wn != '0;
  end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back select + 32xDW register file; rd1/rd2 bypassed read ports, dbg_data unbypassed, wr_data/wr_en forward, wr_cnt commit count; clk, rst (sync active-low)
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    wb_ctl,
  input  logic [DW-1:0] wb_rd,
  input  logic [DW-1:0] wb_pc,
  input  logic [DW-1:0] wb_alu,
  input  logic [AW-1:0] wb_wn,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic [DW-1:0] wr_data,
  output logic          wr_en,
  output logic [CW-1:0] wr_cnt
);
  logic [DW-1:0] r_regs [2**AW];
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] w_data;
  logic          w_en;
  wb_mux #(.DW(DW), .AW(AW)) u_mux (
    .rst(rst), .wb_ctl(wb_ctl), .wb_rd(wb_rd), .wb_pc(wb_pc),
    .wb_alu(wb_alu), .wb_wn(wb_wn), .wr_data(w_data), .wr_en(w_en)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_regs <= '{default: '0};
      r_cnt  <= '0;
    end else if (w_en) begin
      r_regs[wb_wn] <= w_data;
      r_cnt         <= r_cnt + CW'(1);
    end
  end
  always_comb begin
    rd1      = !rst || ra1 == '0 ? '0 : w_en && ra1 == wb_wn ? w_data : r_regs[ra1];
    rd2      = !rst || ra2 == '0 ? '0 : w_en && ra2 == wb_wn ? w_data : r_regs[ra2];
    dbg_data = rst ? r_regs[dbg_addr] : '0;
    wr_cnt   = rst ? r_cnt : '0;
    wr_data  = w_data;
    wr_en    = w_en;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline register. Consumes the registered WB control, memory read data, PC, ALU result and destination register number.
- Selects the write-back value and commits it to a 32x32 architectural register file.
- Provides two decode-stage read ports with write-through bypass, a debug read port, and a committed-write counter.
- Sits between the MEM/WB register outputs and the ID stage.

Parameters:
- DW, 32, data/register width in bits
- AW, 5, register address width; register count = 2**AW
- CW, 32, committed-write counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low
- wb_ctl  in  2  WB control field from MEM/WB (encoding below)
- wb_rd  in  DW  memory read data from MEM/WB
- wb_pc  in  DW  instruction address from MEM/WB
- wb_alu  in  DW  ALU result from MEM/WB
- wb_wn  in  AW  destination register number from MEM/WB
- ra1  in  AW  read address, port 1 (rs)
- ra2  in  AW  read address, port 2 (rt)
- rd1  out  DW  read data, port 1
- rd2  out  DW  read data, port 2
- dbg_addr  in  AW  debug read address
- dbg_data  out  DW  debug read data (no bypass)
- wr_data  out  DW  selected write-back value (for EX forwarding)
- wr_en  out  1  write-back commit strobe (for EX forwarding)
- wr_cnt  out  CW  committed-write counter

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-low.
- wb_ctl encoding:
  - 00: no write (bubble)
  - 01: write wb_alu
  - 10: write wb_rd
  - 11: write link value wb_pc + 4, modulo 2**DW
- wr_data is combinational from the wb_ctl decode. It is 0 when wb_ctl = 00.
- wr_en = (wb_ctl != 00) && (wb_wn != 0) && rst. Writes to r0 are dropped.
- Commit: at the posedge with wr_en = 1, regs[wb_wn] <= wr_data and wr_cnt <= wr_cnt + 1.
  - The counter wraps from 2**CW - 1 to 0.
  - A dropped write (r0 or bubble) does not count.
- Register 0 is never written and always reads 0 on every port.
- Read ports rd1/rd2 are combinational:
  - If raN == 0, output 0.
  - Else if wr_en && raN == wb_wn, output wr_data (write-through bypass, same cycle).
  - Else output regs[raN].
- Both ports may read the same address. Both bypass simultaneously when matching.
- dbg_data = regs[dbg_addr], combinational, never bypassed. It shows the pre-commit value during a write cycle.
- Reset (rst = 0 at a posedge):
  - All registers clear to 0 and wr_cnt clears to 0.
  - Any write presented that cycle is discarded.
- While rst = 0:
  - rd1, rd2, dbg_data, wr_en and wr_cnt read 0.
  - wr_data still reflects the wb_ctl decode.
- Reset asserted mid-stream:
  - The in-flight write is lost.
  - The first write after rst returns to 1 commits normally on the next posedge.
- No stall or enable input. One write per cycle maximum; back-to-back writes to the same register are legal, last wins.
- Latency: a write is visible at rd1/rd2 in the same cycle (bypass) and from the register array from the next cycle on.

Decomposition:
- Shared package `mips_pkg`:
  - WB encoding constants WB_NONE = 2'b00, WB_ALU = 2'b01, WB_MEM = 2'b10, WB_LINK = 2'b11
  - LINK_OFFSET = 4
  - DW and AW defaults
  - Consumed by the decoder and the MEM/WB register as well as this block.
- One natural sub-module: `wb_mux`, the combinational wb_ctl -> wr_data/wr_en select. It is reused by the EX forwarding unit.
- The register array and counter stay in the top.

Test Plan:
- Reset: rst = 0 for 2 cycles with wb_ctl = 01, wb_wn = 5, wb_alu = 32'hDEAD_BEEF -> after release, dbg r5 = 0, wr_cnt = 0.
- Select paths, each checked via dbg_data next cycle and wr_cnt = 3:
  - wb_ctl = 01, wn = 8, alu = 32'h1234 -> r8 = 32'h1234
  - wb_ctl = 10, wn = 9, rd = 32'hCAFE_0000 -> r9 = 32'hCAFE_0000
  - wb_ctl = 11, wn = 31, pc = 32'h0040_0010 -> r31 = 32'h0040_0014
- r0 and bubbles:
  - wb_ctl = 01, wn = 0, alu = 32'hFFFF_FFFF -> rd1 (ra1 = 0) = 0, wr_en = 0, wr_cnt unchanged
  - wb_ctl = 00, wn = 4 -> r4 unchanged
- Bypass: r3 = 32'h11, then wb_ctl = 01, wn = 3, alu = 32'h22 with ra1 = ra2 = 3 -> same-cycle rd1 = rd2 = 32'h22, dbg r3 = 32'h11; next cycle dbg r3 = 32'h22.
- Link wrap: wb_ctl = 11, wn = 31, pc = 32'hFFFF_FFFC -> r31 = 0. Counter wrap with CW = 4: 16 writes -> wr_cnt = 0.
- Mid-stream reset: 10 writes to r1..r10, then rst = 0 for one cycle with a write to r11 pending -> all registers 0, wr_cnt = 0, r11 = 0.
